// File: rtl/plic_pkg.sv
// ============================================================================
// Module : plic_pkg
// Shared register offsets, gateway state encoding and default priority width.
// Revision: 1.0
// ============================================================================
`default_nettype none

package plic_pkg;

    localparam int PRIO_W_DEFAULT = 3;

    localparam logic [11:0] OFF_PRIO    = 12'h000;
    localparam logic [11:0] OFF_PENDING = 12'h080;
    localparam logic [11:0] OFF_ENABLE  = 12'h100;
    localparam logic [11:0] OFF_THRESH  = 12'h200;
    localparam logic [11:0] OFF_CLAIM   = 12'h204;

    typedef enum logic [1:0] {
        GW_IDLE      = 2'd0,
        GW_PENDING   = 2'd1,
        GW_INSERVICE = 2'd2
    } gw_state_e;

endpackage

`default_nettype wire

// File: rtl/plic_gateway.sv
// ============================================================================
// Module : plic_gateway
// Per-source level gateway: IDLE -> PENDING -> INSERVICE -> IDLE.
// Revision: 1.0
// ============================================================================
`default_nettype none

module plic_gateway
    import plic_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic claim,
    input  logic complete,
    output logic pending
);

    gw_state_e state_q;
    gw_state_e state_d;

    // The level on src is only looked at while idle; claim/complete drive the rest.
    always_comb begin
        state_d = state_q;
        case (state_q)
            GW_IDLE:      if (src)      state_d = GW_PENDING;
            GW_PENDING:   if (claim)    state_d = GW_INSERVICE;
            GW_INSERVICE: if (complete) state_d = GW_IDLE;
            default:                    state_d = GW_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= GW_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign pending = (state_q == GW_PENDING);

endmodule

`default_nettype wire

// File: rtl/plic.sv
// ============================================================================
// Module : plic
// Platform interrupt controller: register file, gateways and priority arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module plic
    import plic_pkg::*;
#(
    parameter int NSRC   = 8,
    parameter int PRIO_W = PRIO_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bus_req,
    input  logic            bus_we,
    input  logic [11:0]     bus_addr,
    input  logic [31:0]     bus_wdata,
    output logic [31:0]     bus_rdata,
    output logic            bus_ack,
    output logic            bus_err,
    input  logic [NSRC-1:0] src,
    output logic            irq_ext
);

    localparam int ID_W = $clog2(NSRC + 1);

    logic [NSRC:1][PRIO_W-1:0] prio_q, prio_d;
    logic [NSRC:1]             enable_q, enable_d;
    logic [PRIO_W-1:0]         thresh_q, thresh_d;
    logic                      ack_q, ack_d;
    logic                      err_q, err_d;
    logic [31:0]               rdata_q, rdata_d;
    logic                      irq_q, irq_d;

    logic [NSRC:1]     pending;
    logic [NSRC:1]     claim_vec;
    logic [NSRC:1]     complete_vec;
    logic [ID_W-1:0]   best_id;
    logic [PRIO_W-1:0] best_prio;
    logic [11:0]       word_addr;
    logic [31:0]       rd_val;
    logic              mapped;
    logic              unused_addr_bits;

    assign word_addr        = {bus_addr[11:2], 2'b00};
    assign unused_addr_bits = ^bus_addr[1:0];

    for (genvar g = 1; g <= NSRC; g++) begin : g_gw
        plic_gateway u_gw (
            .clk      (clk),
            .rst      (rst),
            .src      (src[g-1]),
            .claim    (claim_vec[g]),
            .complete (complete_vec[g]),
            .pending  (pending[g])
        );
    end

    // Ascending scan with strict compare keeps the lowest ID on ties.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int i = 1; i <= NSRC; i++) begin
            if (pending[i] && enable_q[i] && (prio_q[i] > best_prio)) begin
                best_prio = prio_q[i];
                best_id   = ID_W'(i);
            end
        end
    end

    always_comb begin
        mapped = 1'b1;
        rd_val = '0;
        if (word_addr[11:7] == OFF_PRIO[11:7]) begin
            mapped = (int'(word_addr[6:2]) <= NSRC);
            for (int i = 1; i <= NSRC; i++) begin
                if (int'(word_addr[6:2]) == i) rd_val[PRIO_W-1:0] = prio_q[i];
            end
        end else begin
            case (word_addr)
                OFF_PENDING: rd_val[NSRC:1]     = pending;
                OFF_ENABLE:  rd_val[NSRC:1]     = enable_q;
                OFF_THRESH:  rd_val[PRIO_W-1:0] = thresh_q;
                OFF_CLAIM:   rd_val[ID_W-1:0]   = best_id;
                default:     mapped             = 1'b0;
            endcase
        end
    end

    always_comb begin
        prio_d       = prio_q;
        enable_d     = enable_q;
        thresh_d     = thresh_q;
        ack_d        = bus_req && !ack_q;
        err_d        = 1'b0;
        rdata_d      = '0;
        claim_vec    = '0;
        complete_vec = '0;
        irq_d        = (best_prio > thresh_q);

        if (bus_req && !ack_q) begin
            err_d = !mapped;
            if (!bus_we) begin
                if (mapped) rdata_d = rd_val;
                if (word_addr == OFF_CLAIM && best_id != '0) claim_vec[best_id] = 1'b1;
            end else if (mapped) begin
                if (word_addr[11:7] == OFF_PRIO[11:7]) begin
                    for (int i = 1; i <= NSRC; i++) begin
                        if (int'(word_addr[6:2]) == i) prio_d[i] = bus_wdata[PRIO_W-1:0];
                    end
                end else begin
                    case (word_addr)
                        OFF_ENABLE: enable_d = bus_wdata[NSRC:1];
                        OFF_THRESH: thresh_d = bus_wdata[PRIO_W-1:0];
                        // Gateway ignores the pulse unless it is in service.
                        OFF_CLAIM: begin
                            for (int i = 1; i <= NSRC; i++) begin
                                if (bus_wdata == 32'(i)) complete_vec[i] = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q   <= '0;
            enable_q <= '0;
            thresh_q <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            prio_q   <= prio_d;
            enable_q <= enable_d;
            thresh_q <= thresh_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    assign bus_ack   = ack_q;
    assign bus_err   = err_q;
    assign bus_rdata = rdata_q;
    assign irq_ext   = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_plic.sv
// ============================================================================
// Module : tb_plic
// Directed vector table plus hand-written interrupt sequences for plic.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_plic;

    localparam int NSRC = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            bus_req = 1'b0;
    logic            bus_we = 1'b0;
    logic [11:0]     bus_addr = '0;
    logic [31:0]     bus_wdata = '0;
    logic [31:0]     bus_rdata;
    logic            bus_ack;
    logic            bus_err;
    logic [NSRC-1:0] src = '0;
    logic            irq_ext;

    int n_pass  = 0;
    int n_total = 0;

    plic #(.NSRC(NSRC), .PRIO_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err),
        .src       (src),
        .irq_ext   (irq_ext)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    // One access: drive on a falling edge, sampled on the next rising edge,
    // ack observed on the following falling edge.
    task automatic bus(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic ack, output logic err);
        @(negedge clk);
        bus_req   = 1'b1;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wdata;
        @(negedge clk);
        rdata   = bus_rdata;
        ack     = bus_ack;
        err     = bus_err;
        bus_req = 1'b0;
        bus_we  = 1'b0;
    endtask

    task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic a, e;
        bus(1'b0, addr, '0, d, a, e);
        check({name, "_ack"}, {31'd0, a}, 32'd1);
        check(name, d, exp);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        logic [31:0] d;
        logic a, e;
        bus(1'b1, addr, data, d, a, e);
        check("wr_ack_noerr", {30'd0, a, e}, 32'd2);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        logic a, e;

        vecs[0]  = '{1'b1, 12'h004, 32'h5,   32'h0,   1'b0};
        vecs[1]  = '{1'b0, 12'h004, 32'h0,   32'h5,   1'b0};
        vecs[2]  = '{1'b1, 12'h004, 32'hFF,  32'h0,   1'b0};
        vecs[3]  = '{1'b0, 12'h004, 32'h0,   32'h7,   1'b0};
        vecs[4]  = '{1'b0, 12'h000, 32'h0,   32'h0,   1'b0};
        vecs[5]  = '{1'b1, 12'h100, 32'h1FF, 32'h0,   1'b0};
        vecs[6]  = '{1'b0, 12'h100, 32'h0,   32'h1FE, 1'b0};
        vecs[7]  = '{1'b1, 12'h200, 32'hF,   32'h0,   1'b0};
        vecs[8]  = '{1'b0, 12'h200, 32'h0,   32'h7,   1'b0};
        vecs[9]  = '{1'b0, 12'h300, 32'h0,   32'h0,   1'b1};
        vecs[10] = '{1'b1, 12'h080, 32'h1,   32'h0,   1'b0};
        vecs[11] = '{1'b1, 12'h3FC, 32'h5,   32'h0,   1'b1};
        vecs[12] = '{1'b0, 12'h204, 32'h0,   32'h0,   1'b0};
        vecs[13] = '{1'b1, 12'h100, 32'h0,   32'h0,   1'b0};
        vecs[14] = '{1'b1, 12'h200, 32'h0,   32'h0,   1'b0};
        vecs[15] = '{1'b1, 12'h004, 32'h0,   32'h0,   1'b0};

        // Reset state
        cyc(3);
        check("rst_ack", {31'd0, bus_ack}, 32'd0);
        check("rst_irq", {31'd0, irq_ext}, 32'd0);
        check("rst_rdata", bus_rdata, 32'd0);
        rst = 1'b0;
        rd("rst_prio1", 12'h004, 32'h0);
        rd("rst_enable", 12'h100, 32'h0);
        rd("rst_thresh", 12'h200, 32'h0);
        rd("rst_pending", 12'h080, 32'h0);

        // Register-file vectors
        for (int i = 0; i < 16; i++) begin
            bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, d, a, e);
            check($sformatf("vec%0d_ack", i), {31'd0, a}, 32'd1);
            check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
        end

        // Single source: latency of pending and irq, claim, irq drop
        wr(12'h00C, 32'd2);
        wr(12'h100, 32'h08);
        wr(12'h200, 32'd0);
        @(negedge clk);
        src = 8'h04;
        cyc(1);
        check("lat_irq_n1", {31'd0, irq_ext}, 32'd0);
        cyc(1);
        check("lat_irq_n2", {31'd0, irq_ext}, 32'd1);
        src = '0;
        rd("claim_id3", 12'h204, 32'd3);
        cyc(2);
        check("irq_after_claim", {31'd0, irq_ext}, 32'd0);
        rd("pending_inservice", 12'h080, 32'h0);
        wr(12'h204, 32'd3);

        // Tie at equal priority resolves to the lowest ID
        wr(12'h008, 32'd4);
        wr(12'h014, 32'd4);
        wr(12'h100, 32'h24);
        @(negedge clk);
        src = 8'h12;
        cyc(1);
        src = '0;
        cyc(1);
        rd("pending_2_5", 12'h080, 32'h24);
        rd("claim_tie_2", 12'h204, 32'd2);
        rd("claim_tie_5", 12'h204, 32'd5);
        rd("claim_none", 12'h204, 32'd0);
        wr(12'h204, 32'd2);
        wr(12'h204, 32'd5);

        // Threshold is a strict compare
        wr(12'h200, 32'd4);
        wr(12'h018, 32'd4);
        wr(12'h100, 32'h40);
        @(negedge clk);
        src = 8'h20;
        cyc(1);
        src = '0;
        cyc(3);
        check("thr_eq_irq", {31'd0, irq_ext}, 32'd0);
        wr(12'h200, 32'd3);
        cyc(1);
        check("thr_below_irq", {31'd0, irq_ext}, 32'd1);
        rd("claim_id6", 12'h204, 32'd6);
        wr(12'h204, 32'd6);
        wr(12'h200, 32'd0);

        // Complete of a non-in-service ID is ignored
        wr(12'h004, 32'd1);
        wr(12'h100, 32'h02);
        @(negedge clk);
        src = 8'h01;
        cyc(2);
        rd("claim_id1", 12'h204, 32'd1);
        wr(12'h204, 32'd7);
        rd("still_inservice", 12'h080, 32'h0);
        rd("claim_after_bad", 12'h204, 32'd0);
        wr(12'h204, 32'd1);
        cyc(1);
        rd("repend_id1", 12'h080, 32'h02);
        check("repend_irq", {31'd0, irq_ext}, 32'd1);
        wr(12'h080, 32'h0);
        rd("pending_ro", 12'h080, 32'h02);

        // Reset during an access aborts it
        @(negedge clk);
        bus_req  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = 12'h100;
        #2;
        rst = 1'b1;
        src = '0;
        #1;
        check("async_rst_irq", {31'd0, irq_ext}, 32'd0);
        @(negedge clk);
        check("rst_abort_ack", {31'd0, bus_ack}, 32'd0);
        bus_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rd("post_rst_pending", 12'h080, 32'h0);
        rd("post_rst_enable", 12'h100, 32'h0);
        check("post_rst_irq", {31'd0, irq_ext}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/plic.md
PLIC -- requirements
Module: plic

Interface
REQ-001 Parameter NSRC, default 8, number of interrupt sources; IDs 1..NSRC, ID 0 reserved as "none".
REQ-002 Parameter PRIO_W, default 3, priority field width.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 bus_req  input  1  D-bus slave request; held until bus_ack.
REQ-006 bus_we  input  1  1 = write, 0 = read.
REQ-007 bus_addr  input  12  byte offset within the 4 KiB PLIC window; bits [1:0] ignored.
REQ-008 bus_wdata  input  32  write data.
REQ-009 bus_rdata  output  32  read data, valid only while bus_ack=1, else 0.
REQ-010 bus_ack  output  1  one-cycle completion pulse.
REQ-011 bus_err  output  1  asserted with bus_ack for unmapped offsets.
REQ-012 src  input  NSRC  level-sensitive interrupt lines, bit i-1 = source ID i, synchronous to clk.
REQ-013 irq_ext  output  1  machine external interrupt to core, registered.

Function
REQ-014 Register map: 0x000+4*i priority[i] (RW, i=1..NSRC, low PRIO_W bits, i=0 reads 0); 0x080 pending (RO, bit i = ID i); 0x100 enable (RW, bit i = ID i, bit 0 hardwired 0); 0x200 threshold (RW, PRIO_W bits); 0x204 claim (read) / complete (write); all other offsets unmapped.
REQ-015 Bus: request sampled when bus_req=1 and no ack in progress; bus_ack asserted exactly the following cycle; one outstanding access; no back-to-back ack without bus_req low or re-sampled after ack.
REQ-016 Unmapped access: writes discarded, read data 0, bus_err=1 with bus_ack.
REQ-017 Gateway per source, states IDLE, PENDING, INSERVICE: IDLE->PENDING when src=1; PENDING->INSERVICE on claim of that ID; INSERVICE->IDLE on complete of that ID; src ignored in PENDING and INSERVICE.
REQ-018 Best candidate: highest priority among pending&enabled sources with priority>0; ties resolved to lowest ID; none gives ID 0.
REQ-019 irq_ext registered: 1 the cycle after best candidate priority > threshold; src rising at cycle n gives pending at n+1 and irq_ext at n+2.
REQ-020 Claim read returns best ID evaluated in the request cycle; nonzero ID moves that source to INSERVICE in the same edge as bus_ack; ID 0 changes no state.
REQ-021 Complete write: ID in range and INSERVICE returns the source to IDLE; any other value ignored, bus_err=0.
REQ-022 Simultaneous claim and src assertion on the same ID: claim wins, source ends INSERVICE.
REQ-023 Priority or enable change takes effect on the candidate the next cycle; a disabled pending source stays PENDING.
REQ-024 Writes to pending register have no effect, ack with bus_err=0.

Reset
REQ-025 On rst: priorities, enable, threshold 0; all gateways IDLE; irq_ext, bus_ack, bus_err 0; bus_rdata 0.
REQ-026 rst mid-access aborts it with no ack; first request after deassertion is serviced normally.

Structure
REQ-027 Register offsets, gateway state enum and PRIO_W default live in shared package plic_pkg.
REQ-028 Per-source gateway is sub-module plic_gateway, instantiated NSRC times; arbitration tree and register file stay in plic.

Verification
REQ-029 prio[3]=2, enable=0x08, threshold=0, src[2]=1 at cycle 10 -> irq_ext=1 at cycle 12; claim read returns 3; irq_ext=0 two cycles later.
REQ-030 IDs 2 and 5 both priority 4, both enabled and pending -> claim returns 2; next claim returns 5; third claim returns 0.
REQ-031 threshold=4, only pending source priority 4 -> irq_ext stays 0; threshold=3 -> irq_ext=1 two cycles later.
REQ-032 Claim ID 1, src[0] held high, complete 7 (not in service) -> ID 1 stays INSERVICE; complete 1 -> pending bit 1 set next cycle.
REQ-033 Read offset 0x300 -> bus_ack=1, bus_err=1, bus_rdata=0; write 0x080 -> pending unchanged.
REQ-034 rst asserted during an access with pending sources -> no ack, pending 0, irq_ext 0; after release, enable read returns 0.
